// File: rtl/load_pkg.sv
// load_pkg: shared types for the load alignment/extension buffer
package load_pkg;
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } load_size_t;

    // Reserved encoding behaves as a plain (non-merging) load.
    typedef enum logic [1:0] {
        MG_NONE  = 2'b00,
        MG_LEFT  = 2'b01,
        MG_RIGHT = 2'b10,
        MG_RSVD  = 2'b11
    } merge_t;

    localparam int LOAD_DATA_W_MAX = 64;
    localparam int LOAD_TAG_W_MAX  = 8;

    // Widest form of a queued result; instances size their own copy from DATA_W/TAG_W.
    typedef struct packed {
        logic [LOAD_DATA_W_MAX-1:0] data;
        logic [LOAD_TAG_W_MAX-1:0]  tag;
        logic                       err;
    } load_entry_t;
endpackage

// File: rtl/load_format.sv
// load_format: combinational align, sign/zero-extend, merge and alignment-error check
// Ports: in_data/in_addr_lo/in_size/in_sign raw load response; in_merge/in_old only
// with LOAD_MERGE_EN (LWL/LWR-style partial merge); fmt_data/fmt_err formatted result.
module load_format
    import load_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int B      = DATA_W / 8,
    localparam int A      = $clog2(B)
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [A-1:0]      in_addr_lo,
    input  load_size_t        in_size,
    input  logic              in_sign,
`ifdef LOAD_MERGE_EN
    input  merge_t            in_merge,
    input  logic [DATA_W-1:0] in_old,
`endif
    output logic [DATA_W-1:0] fmt_data,
    output logic              fmt_err
);
    // Keep the low `bits` bits of v and fill the rest with its top bit when sgn is set.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input int bits, input logic sgn);
        logic [DATA_W-1:0] m;
        m = ~({DATA_W{1'b1}} << bits);
        return (v & m) | ({DATA_W{sgn & v[bits-1]}} & ~m);
    endfunction

    logic [DATA_W-1:0] s, ext;
    logic              err;

    // Shifting by the full lane is exact for every legal access; misaligned ones are zeroed anyway.
    assign s   = in_data >> {in_addr_lo, 3'b000};
    assign ext = extend(s, in_size == SZ_B ? 8 : in_size == SZ_H ? 16 : in_size == SZ_W ? 32 : DATA_W, in_sign);
    assign err = in_size == SZ_H ? in_addr_lo[0] :
                 in_size == SZ_W ? |in_addr_lo[1:0] :
                 in_size == SZ_D ? (DATA_W == 32) || (|in_addr_lo) : 1'b0;

`ifdef LOAD_MERGE_EN
    logic [A+2:0]      sh_l, sh_r;
    logic [DATA_W-1:0] mg_l, mg_r;
    logic              mg;

    assign sh_r = {in_addr_lo, 3'b000};
    assign sh_l = {A'(B - 1) - in_addr_lo, 3'b000};
    assign mg_l = (in_data << sh_l) | (in_old & ~({DATA_W{1'b1}} << sh_l));
    assign mg_r = (in_data >> sh_r) | (in_old & ~({DATA_W{1'b1}} >> sh_r));
    assign mg   = in_merge == MG_LEFT || in_merge == MG_RIGHT;

    assign fmt_data = in_merge == MG_LEFT ? mg_l : in_merge == MG_RIGHT ? mg_r : err ? '0 : ext;
    assign fmt_err  = !mg && err;
`else
    assign fmt_data = err ? '0 : ext;
    assign fmt_err  = err;
`endif
endmodule

// File: rtl/load_align_buffer.sv
// load_align_buffer: formats load responses and queues them in a DEPTH-entry result FIFO for WB
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/in_data/in_addr_lo/in_size/
// in_sign/in_tag response side; out_valid/out_ready/out_data/out_tag/out_err head of FIFO;
// out_count occupancy. Macro LOAD_MERGE_EN adds in_merge/in_old for unaligned merge loads.
module load_align_buffer
    import load_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 2,
    parameter  int TAG_W  = 5,
    localparam int A      = $clog2(DATA_W / 8),
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [A-1:0]      in_addr_lo,
    input  logic [1:0]        in_size,
    input  logic              in_sign,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef LOAD_MERGE_EN
    input  logic [1:0]        in_merge,
    input  logic [DATA_W-1:0] in_old,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CW-1:0]     out_count
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_err, push, pop;

    load_format #(.DATA_W(DATA_W)) u_fmt (
        .in_data    (in_data),
        .in_addr_lo (in_addr_lo),
        .in_size    (load_size_t'(in_size)),
        .in_sign    (in_sign),
`ifdef LOAD_MERGE_EN
        .in_merge   (merge_t'(in_merge)),
        .in_old     (in_old),
`endif
        .fmt_data   (fmt_data),
        .fmt_err    (fmt_err)
    );

    assign in_ready  = !rst && (count_q < CW'(DEPTH));
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_d      = push ? wr_q + PW'(1) : wr_q;
    assign rd_d      = pop ? rd_q + PW'(1) : rd_q;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            count_q <= count_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Storage needs no reset: an entry is only visible while count covers it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{data: fmt_data, tag: in_tag, err: fmt_err};
    end

    assign out_data  = out_valid ? mem_q[rd_q].data : '0;
    assign out_tag   = out_valid ? mem_q[rd_q].tag : '0;
    assign out_err   = out_valid && mem_q[rd_q].err;
    assign out_count = count_q;
endmodule

// File: tb/tb_load_align_buffer.sv
// tb_load_align_buffer: 32-bit and 64-bit instances checked against a byte-level queue model
module tb_load_align_buffer;
    localparam int TAG_W = 5;
    localparam int D32   = 2;
    localparam int D64   = 4;

    typedef struct {
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        logic             e;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
    logic [63:0]      in_data = '0;
    logic [2:0]       lane = '0;
    logic [1:0]       in_size = '0;
    logic [TAG_W-1:0] in_tag = '0;
`ifdef LOAD_MERGE_EN
    logic [1:0]       in_merge = '0;
    logic [63:0]      in_old = '0;
`endif
    logic             r32, v32, e32, r64, v64, e64;
    logic [31:0]      d32;
    logic [63:0]      d64;
    logic [TAG_W-1:0] t32, t64;
    logic [1:0]       c32;
    logic [2:0]       c64;
    int               checks = 0, errors = 0;
    bit               chk_on = 1'b0;
    ent_t             q32[$], q64[$];

    always #5 clk = ~clk;

    load_align_buffer #(.DATA_W(32), .DEPTH(D32), .TAG_W(TAG_W)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_data(in_data[31:0]), .in_addr_lo(lane[1:0]), .in_size(in_size), .in_sign(in_sign), .in_tag(in_tag),
`ifdef LOAD_MERGE_EN
        .in_merge(in_merge), .in_old(in_old[31:0]),
`endif
        .out_valid(v32), .out_ready(out_ready), .out_data(d32), .out_tag(t32), .out_err(e32), .out_count(c32)
    );

    load_align_buffer #(.DATA_W(64), .DEPTH(D64), .TAG_W(TAG_W)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_data(in_data), .in_addr_lo(lane), .in_size(in_size), .in_sign(in_sign), .in_tag(in_tag),
`ifdef LOAD_MERGE_EN
        .in_merge(in_merge), .in_old(in_old),
`endif
        .out_valid(v64), .out_ready(out_ready), .out_data(d64), .out_tag(t64), .out_err(e64), .out_count(c64)
    );

    // Returns {err, data}: take 2^sz bytes starting at byte ln, extend to dw bits.
    function automatic logic [64:0] fmt(input logic [63:0] data, input int ln, input int sz, input bit sg, input int dw);
        int n;
        logic [63:0] v, m;
        n = 1 << sz;
        if (n > dw / 8 || ln % n != 0) return {1'b1, 64'd0};
        m = (n == 8) ? '1 : (64'd1 << (n * 8)) - 64'd1;
        v = (data >> (ln * 8)) & m;
        if (sg && n * 8 < dw && v[n * 8 - 1]) v = v | ~m;
        if (dw == 32) v = v & 64'hFFFF_FFFF;
        return {1'b0, v};
    endfunction

`ifdef LOAD_MERGE_EN
    function automatic logic [63:0] mrg(input logic [63:0] mem, input logic [63:0] old, input int k, input int mode, input int dw);
        int b;
        logic [63:0] r;
        b = dw / 8;
        r = '0;
        for (int i = 0; i < b; i++) begin
            if (mode == 1) r[i*8 +: 8] = (i >= b - 1 - k) ? mem[(i - (b - 1 - k))*8 +: 8] : old[i*8 +: 8];
            else           r[i*8 +: 8] = (i <= b - 1 - k) ? mem[(i + k)*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction
`endif

    function automatic ent_t exp_ent(input int dw);
        logic [63:0] d;
        logic [64:0] r;
        int          ln;
        ent_t        e;
        d  = (dw == 32) ? {32'd0, in_data[31:0]} : in_data;
        ln = (dw == 32) ? int'(lane[1:0]) : int'(lane);
        r  = fmt(d, ln, int'(in_size), in_sign, dw);
        e.d = r[63:0];
        e.e = r[64];
        e.t = in_tag;
`ifdef LOAD_MERGE_EN
        if (in_merge == 2'b01 || in_merge == 2'b10) begin
            e.d = mrg(d, (dw == 32) ? {32'd0, in_old[31:0]} : in_old, ln, int'(in_merge), dw);
            e.e = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Model state advances on the same edge as the DUT, using the inputs held across it.
    always @(posedge clk) begin
        if (rst || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (in_valid && q32.size() < D32) begin
                if (out_ready && q32.size() != 0) void'(q32.pop_front());
                q32.push_back(exp_ent(32));
            end else if (out_ready && q32.size() != 0) void'(q32.pop_front());
            if (in_valid && q64.size() < D64) begin
                if (out_ready && q64.size() != 0) void'(q64.pop_front());
                q64.push_back(exp_ent(64));
            end else if (out_ready && q64.size() != 0) void'(q64.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rdy32", 65'(r32), 65'(!rst && q32.size() < D32));
            chk("vld32", 65'(v32), 65'(q32.size() != 0));
            chk("cnt32", 65'(c32), 65'(q32.size()));
            chk("dat32", 65'(d32), q32.size() != 0 ? 65'(q32[0].d) : 65'd0);
            chk("tag32", 65'(t32), q32.size() != 0 ? 65'(q32[0].t) : 65'd0);
            chk("err32", 65'(e32), q32.size() != 0 ? 65'(q32[0].e) : 65'd0);
            chk("rdy64", 65'(r64), 65'(!rst && q64.size() < D64));
            chk("vld64", 65'(v64), 65'(q64.size() != 0));
            chk("cnt64", 65'(c64), 65'(q64.size()));
            chk("dat64", 65'(d64), q64.size() != 0 ? 65'(q64[0].d) : 65'd0);
            chk("tag64", 65'(t64), q64.size() != 0 ? 65'(q64[0].t) : 65'd0);
            chk("err64", 65'(e64), q64.size() != 0 ? 65'(q64[0].e) : 65'd0);
        end
    end

    task automatic step(input bit v, input logic [63:0] d, input int ln, input int sz, input bit sg,
                        input int tg, input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        lane      = 3'(ln);
        in_size   = 2'(sz);
        in_sign   = sg;
        in_tag    = TAG_W'(tg);
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk("m_b_s",   fmt(64'h8000_F0A5, 0, 0, 1, 32), {1'b0, 64'hFFFF_FFA5});
        chk("m_b_u",   fmt(64'h8000_F0A5, 3, 0, 0, 32), {1'b0, 64'h80});
        chk("m_h_err", fmt(64'h8123_4567, 1, 1, 1, 32), {1'b1, 64'h0});
        chk("m_w64",   fmt(64'h8000_0001_0000_0002, 4, 2, 1, 64), {1'b0, 64'hFFFF_FFFF_8000_0001});
        chk("m_d32",   fmt(64'h1, 0, 3, 0, 32), {1'b1, 64'h0});
`ifdef LOAD_MERGE_EN
        chk("m_mg_l",  65'(mrg(64'h1122_3344, 64'hAABB_CCDD, 1, 1, 32)), 65'h3344_CCDD);
        chk("m_mg_r",  65'(mrg(64'h1122_3344, 64'hAABB_CCDD, 2, 2, 32)), 65'hAABB_1122);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        rst    = 1'b0;
        chk("rst_cnt", 65'(c32), 65'd0);

        step(1, 64'h8000_F0A5, 0, 0, 1, 1, 0, 0);
        chk("b_s_l0", 65'(d32), 65'hFFFF_FFA5);
        chk("lat_vld", 65'(v32), 65'd1);
        step(1, 64'h8000_F0A5, 3, 0, 0, 2, 1, 0);
        chk("b_u_l3", 65'(d32), 65'h80);
        chk("pp_cnt", 65'(c32), 65'd1);
        chk("pp_tag", 65'(t32), 65'd2);
        step(1, 64'h8123_4567, 2, 1, 1, 3, 1, 0);
        chk("h_s_l2", 65'(d32), 65'hFFFF_8123);
        step(1, 64'h8123_4567, 1, 1, 1, 4, 1, 0);
        chk("h_err", 65'(e32), 65'd1);
        chk("h_err_d", 65'(d32), 65'd0);
        chk("h_err_t", 65'(t32), 65'd4);

        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("fl_cnt", 65'(c32), 65'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 64'(i), 0, 2, 0, 10 + i, 0, 0);
            if (i == 1) chk("full_rdy", 65'(r32), 65'd0);
        end
        chk("full_cnt", 65'(c32), 65'd2);
        chk("head10", 65'(t32), 65'd10);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("head11", 65'(t32), 65'd11);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("drained", 65'(v32), 65'd0);

        step(1, 64'h55, 0, 2, 0, 20, 0, 0);
        step(1, 64'h66, 0, 2, 0, 21, 1, 1);
        chk("flpush_vld", 65'(v32), 65'd0);
        chk("flpush_cnt", 65'(c32), 65'd0);

        step(1, 64'h8000_0001_0000_0002, 4, 2, 1, 22, 0, 0);
        chk("w64_l4", 65'(d64), 65'hFFFF_FFFF_8000_0001);
        step(1, 64'h0123_4567_89AB_CDEF, 0, 3, 0, 23, 1, 0);
        chk("d64", 65'(d64), 65'h0123_4567_89AB_CDEF);
        chk("d32_err", 65'(e32), 65'd1);

`ifdef LOAD_MERGE_EN
        in_old   = 64'hAABB_CCDD;
        in_merge = 2'b01;
        step(1, 64'h1122_3344, 1, 0, 0, 24, 1, 0);
        chk("mg_left", 65'(d32), 65'h3344_CCDD);
        in_merge = 2'b10;
        step(1, 64'h1122_3344, 2, 0, 0, 25, 1, 0);
        chk("mg_right", 65'(d32), 65'hAABB_1122);
        in_merge = 2'b00;
`endif

        step(1, 64'h77, 0, 2, 0, 26, 0, 0);
        rst = 1'b1;
        step(1, 64'h88, 0, 2, 0, 27, 0, 0);
        chk("rst_vld", 65'(v32), 65'd0);
        chk("rst_dat", 65'(d32), 65'd0);
        chk("rst_rdy", 65'(r32), 65'd0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
`ifdef LOAD_MERGE_EN
            in_merge = 2'($urandom);
            in_old   = {$urandom, $urandom};
`endif
            step($urandom_range(3) != 0, {$urandom, $urandom}, $urandom_range(7), $urandom_range(3),
                 1'($urandom), $urandom_range(31), $urandom_range(2) != 0, $urandom_range(39) == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_align_buffer.md
Name: load_align_buffer

Overview:
- Parametrised successor to the WB-stage load extender.
- Takes raw memory read data with load type and low address bits, then aligns, sign/zero-extends and checks alignment.
- Pushes the formatted result into a DEPTH-entry valid/ready result FIFO toward register write-back.
- Sits between the data-cache/uncache response path and the WB register-file write port, decoupling memory response timing from WB stalls.

Parameters:
- DATA_W, 32: data width in bits; legal values 32 or 64. B = DATA_W/8 bytes, A = log2(B).
- DEPTH, 2: result FIFO entries; power of 2, at least 2.
- TAG_W, 5: destination-register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous pipeline flush (exception/branch squash).
- in_valid  in  1  raw load response valid.
- in_ready  out  1  block can accept a response this cycle.
- in_data  in  DATA_W  raw memory word.
- in_addr_lo  in  A  low address bits of the load.
- in_size  in  2  access size, load_size_t.
- in_sign  in  1  1 = sign-extend, 0 = zero-extend.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  WB consumes the head.
- out_data  out  DATA_W  formatted result.
- out_tag  out  TAG_W  destination tag of the head.
- out_err  out  1  address-error (AdEL) flag of the head.
- out_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: count=0, read/write pointers=0, out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=0 while rst is high.
- Handshake: push when in_valid&&in_ready; pop when out_valid&&out_ready.
- in_ready = !rst && (count<DEPTH). There is no same-cycle pass-through when full.
- Latency: a response accepted at edge N is visible at the FIFO head after edge N, i.e. out_valid in cycle N+1 if the FIFO was empty.
- FIFO order is strictly in acceptance order.
- Formatting (combinational before the FIFO write). Byte lane = in_addr_lo.
  - SZ_B: lane byte, extended to DATA_W.
  - SZ_H: 16 bits at lane&~1, extended.
  - SZ_W: 32 bits at lane&~3, extended (for DATA_W=32 this is the whole word and in_sign is ignored).
  - SZ_D: whole word; legal only when DATA_W=64.
- Error: halfword with lane[0]!=0, word with lane[1:0]!=0, doubleword with lane!=0, or SZ_D when DATA_W=32.
  - Sets err=1 and stores data=0.
  - The entry is still queued so WB can raise the exception in order.
- Simultaneous push and pop: count unchanged, both pointers advance. A pop when empty or a push when full cannot occur by the handshake rules.
- Pointers wrap modulo DEPTH.
- Flush: next cycle count=0, pointers=0, out_valid=0. Flush beats a same-cycle push and pop; the pushed entry is discarded. Reset beats flush.
- Reset mid-operation discards all entries; output registers return to their reset values.

Optional Feature:
- Macro: LOAD_MERGE_EN (unaligned LWL/LWR, or LDL/LDR when DATA_W=64).
- With the macro: extra ports in_merge (in, 2; 00 none, 01 left, 10 right, 11 reserved and treated as none) and in_old (in, DATA_W; current rt value). k = in_addr_lo.
  - Left: result bytes [B-1 : B-1-k] = mem bytes [k:0]; lower B-1-k bytes from in_old.
  - Right: result bytes [B-1-k : 0] = mem bytes [B-1 : k]; upper k bytes from in_old.
  - Merge loads never set err; size and sign are ignored.
- Without the macro: ports absent, no merge logic, behaviour as above.

Decomposition:
- Shared package load_pkg:
  - load_size_t enum {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_D=2'b11}.
  - merge_t enum.
  - load_entry_t struct {data, tag, err}.
- One natural sub-module: load_format, the pure combinational align/extend/merge/err logic. load_align_buffer instantiates it and owns the FIFO.

Test Plan:
- DATA_W=32: in_data=32'h8000_F0A5, SZ_B sign, lane 0 -> out_data=32'hFFFF_FFA5. Same with lane 3 unsigned -> 32'h0000_0080.
- SZ_H sign, lane 2, in_data=32'h8123_4567 -> 32'hFFFF_8123. Lane 1 -> out_err=1, out_data=0, tag preserved.
- DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after 2 pushes, out_count=2. Raise out_ready -> tags pop in order.
- Simultaneous push+pop at count=1 -> count stays 1. Flush with push in the same cycle -> out_valid=0 next cycle, count=0.
- DATA_W=64: SZ_W sign, lane 4, in_data=64'h8000_0001_0000_0002 -> 64'hFFFF_FFFF_8000_0001. SZ_D lane 0 -> passthrough.
- LOAD_MERGE_EN, DATA_W=32, in_old=32'hAABB_CCDD, in_data=32'h1122_3344:
  - Left k=1 -> 32'h3344_CCDD.
  - Right k=2 -> 32'hAABB_1122.
